// File: rtl/hazard_stall_if.sv
// Pipeline hazard-control bundle: ID/EX/MEM status in, stall/flush/bubble controls out.
interface hazard_stall_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      IF_ID_instruction;
    logic             ID_EX_MemRead;
    logic             ID_EX_RegWrite;
    logic [4:0]       ID_EX_RegisterRd;
    logic             EX_MEM_MemRead;
    logic [4:0]       EX_MEM_RegisterRd;
    logic             ID_EX_MultiCycle;
    logic             BranchTaken;
    logic             Jump;

    logic             PCWrite;
    logic             IF_ID_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Bubble;
    logic             ID_EX_Write;
    logic             EX_MEM_Bubble;
    logic             Busy;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output IF_ID_instruction, ID_EX_MemRead, ID_EX_RegWrite, ID_EX_RegisterRd,
               EX_MEM_MemRead, EX_MEM_RegisterRd, ID_EX_MultiCycle, BranchTaken, Jump,
        input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Write,
               EX_MEM_Bubble, Busy, StallCount
    );

    modport slave (
        input  IF_ID_instruction, ID_EX_MemRead, ID_EX_RegWrite, ID_EX_RegisterRd,
               EX_MEM_MemRead, EX_MEM_RegisterRd, ID_EX_MultiCycle, BranchTaken, Jump,
        output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Write,
               EX_MEM_Bubble, Busy, StallCount
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use, branch-compare and
// multi-cycle EX hazards, taken-branch flush, and a saturating stall-cycle counter.
module hazard_stall_unit #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    hazard_stall_if.slave  hif
);
    localparam int unsigned MdCntW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_MDW  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [MdCntW-1:0]   cnt_q, cnt_d;
    logic                md_done_q, md_done_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_used;
    logic        rt_used;
    logic        is_br;
    logic        ex_match;
    logic        mem_match;
    logic        md_haz;
    logic        h1_haz;
    logic        h2_haz;
    logic [15:0] unused_instr_lo;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic id_ex_write;
    logic ex_mem_bubble;

    // Source-register decode; $0 and unread fields can never match.
    assign op              = hif.IF_ID_instruction[31:26];
    assign rs              = hif.IF_ID_instruction[25:21];
    assign rt              = hif.IF_ID_instruction[20:16];
    assign unused_instr_lo = hif.IF_ID_instruction[15:0];

    assign rs_used = !((op == 6'h02) || (op == 6'h03));
    assign rt_used = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
    assign is_br   = (op == 6'h04) || (op == 6'h05);

    assign ex_match  = (hif.ID_EX_RegisterRd != 5'd0) &&
                       ((rs_used && (hif.ID_EX_RegisterRd == rs)) ||
                        (rt_used && (hif.ID_EX_RegisterRd == rt)));
    assign mem_match = (hif.EX_MEM_RegisterRd != 5'd0) &&
                       ((rs_used && (hif.EX_MEM_RegisterRd == rs)) ||
                        (rt_used && (hif.EX_MEM_RegisterRd == rt)));

    assign md_haz = hif.ID_EX_MultiCycle && !md_done_q;
    assign h2_haz = is_br && hif.ID_EX_MemRead && ex_match;
    assign h1_haz = (!is_br && hif.ID_EX_MemRead && ex_match) ||
                    (is_br && hif.ID_EX_RegWrite && !hif.ID_EX_MemRead && ex_match) ||
                    (is_br && hif.EX_MEM_MemRead && mem_match);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            md_done_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_done_q   <= md_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state and control outputs; decisions are combinational in the detection cycle.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        md_done_d     = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        id_ex_write   = 1'b1;
        ex_mem_bubble = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (md_haz) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    cnt_d         = MdCntW'(MD_LATENCY - 2);
                    state_d       = ST_MDW;
                end else if (h2_haz) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = ST_HOLD;
                end else if (h1_haz) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else begin
                    if_id_flush = hif.BranchTaken | hif.Jump;
                end
            end
            ST_HOLD: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                state_d      = ST_RUN;
            end
            ST_MDW: begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_bubble = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - MdCntW'(1);
                end else begin
                    state_d   = ST_RUN;
                    md_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Reset overrides everything and aborts any HOLD/MDW in progress.
        if (rst) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!rst && !pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign hif.PCWrite       = pc_write;
    assign hif.IF_ID_Write   = if_id_write;
    assign hif.IF_ID_Flush   = if_id_flush;
    assign hif.ID_EX_Bubble  = id_ex_bubble;
    assign hif.ID_EX_Write   = id_ex_write;
    assign hif.EX_MEM_Bubble = ex_mem_bubble;
    assign hif.Busy          = (state_q != ST_RUN);
    assign hif.StallCount    = stall_cnt_q;

endmodule
